// File: rtl/op_sequencer_pkg.sv
// Shared constants and types for the register-bank operation sequencer:
// bank address map, instruction field positions and FSM state encoding.
package op_sequencer_pkg;

  localparam int N_INSTR_DEF = 10;
  localparam int N_OPND_DEF  = 10;

  localparam logic [15:0] ADDR_R0        = 16'h0000;
  localparam logic [15:0] ADDR_I0        = 16'h000A;
  localparam logic [15:0] ADDR_OP_START  = 16'h0014;
  localparam logic [15:0] ADDR_INT_MASK  = 16'h0015;
  localparam logic [15:0] ADDR_INTERRUPT = 16'h0016;

  localparam int OPC_LSB  = 60;
  localparam int DST_LSB  = 8;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_LSB = 0;

  localparam logic [3:0] OPC_END = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RDA   = 3'd2,
    ST_RDB   = 3'd3,
    ST_EXEC  = 3'd4,
    ST_WB    = 3'd5,
    ST_DONE  = 3'd6,
    ST_CLR   = 3'd7
  } state_e;

  // Word posted to INTERRUPT at the end of a run: bit0 = done, bit1 = error.
  function automatic logic [63:0] status_word(input logic err);
    return {62'b0, err, 1'b1};
  endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Bank and execution-unit signals of the sequencer; master = sequencer side.
// ex_req rises with ex_op/ex_a/ex_b stable and holds them until a cycle where
// ex_ack is high; ex_result is taken in that cycle and ex_req drops on the next.
interface op_sequencer_if;
  import op_sequencer_pkg::*;

  logic        op_start;
  logic        int_mask;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        ex_req;
  logic [3:0]  ex_op;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic        ex_ack;
  logic [63:0] ex_result;
  logic        busy;
  logic        interrupt;
  state_e      dbg_state;

  modport master (
    input  op_start, int_mask, rd_data, ex_ack, ex_result,
    output rd_addr, wr_en, wr_addr, wr_data, ex_req, ex_op, ex_a, ex_b,
           busy, interrupt, dbg_state
  );

  modport slave (
    output op_start, int_mask, rd_data, ex_ack, ex_result,
    input  rd_addr, wr_en, wr_addr, wr_data, ex_req, ex_op, ex_a, ex_b,
           busy, interrupt, dbg_state
  );

endinterface

// File: rtl/op_sequencer_instr_decode.sv
// Splits an instruction word into opcode/dst/src1/src2 and flags any register
// index outside R0..R(N_OPND-1).
module instr_decode
  import op_sequencer_pkg::*;
#(
  parameter int N_OPND = N_OPND_DEF
) (
  input  logic [63:0] instr_i,
  output logic [3:0]  opcode_o,
  output logic [3:0]  dst_o,
  output logic [3:0]  src1_o,
  output logic [3:0]  src2_o,
  output logic        bad_idx_o
);

  localparam logic [3:0] IDX_LIMIT = 4'(N_OPND);

  logic unused_reserved;

  assign opcode_o = instr_i[OPC_LSB  +: 4];
  assign dst_o    = instr_i[DST_LSB  +: 4];
  assign src1_o   = instr_i[SRC1_LSB +: 4];
  assign src2_o   = instr_i[SRC2_LSB +: 4];

  assign bad_idx_o = (dst_o >= IDX_LIMIT) || (src1_o >= IDX_LIMIT) ||
                     (src2_o >= IDX_LIMIT);

  assign unused_reserved = ^instr_i[59:12];

endmodule

// File: rtl/op_sequencer.sv
// Control FSM that runs the I0..I9 instruction list against R0..R9 through the
// bank read mux and an external execution unit, then posts status and interrupts.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int N_INSTR = N_INSTR_DEF,
  parameter int N_OPND  = N_OPND_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  op_sequencer_if.master bus
);

  localparam logic [3:0] PC_LAST = 4'(N_INSTR - 1);

  state_e      state_q;
  logic [3:0]  pc_q;
  logic        done_flag_q, done_flag_d;
  logic        err_q;
  logic        op_start_q;
  logic [3:0]  dst_q, src1_q, src2_q;
  logic        ex_req_q;
  logic [3:0]  ex_op_q;
  logic [63:0] ex_a_q, ex_b_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [63:0] wr_data_q;
  logic        busy_q;
  logic        interrupt_q;

  logic        start_rise;
  logic [15:0] rd_mux_addr;
  logic [3:0]  dec_opc, dec_dst, dec_src1, dec_src2;
  logic        dec_bad;

  instr_decode #(.N_OPND(N_OPND)) u_decode (
    .instr_i   (bus.rd_data),
    .opcode_o  (dec_opc),
    .dst_o     (dec_dst),
    .src1_o    (dec_src1),
    .src2_o    (dec_src2),
    .bad_idx_o (dec_bad)
  );

  assign start_rise = bus.op_start & ~op_start_q;

  // Read address is a pure function of state so rd_data is usable the same cycle.
  always_comb begin
    rd_mux_addr = '0;
    case (state_q)
      ST_FETCH: rd_mux_addr = ADDR_I0 + {12'b0, pc_q};
      ST_RDA:   rd_mux_addr = ADDR_R0 + {12'b0, src1_q};
      ST_RDB:   rd_mux_addr = ADDR_R0 + {12'b0, src2_q};
      default:  rd_mux_addr = '0;
    endcase
  end

  always_comb begin
    done_flag_d = done_flag_q;
    if (state_q == ST_IDLE && start_rise) done_flag_d = 1'b0;
    else if (state_q == ST_DONE)          done_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      done_flag_q <= 1'b0;
      err_q       <= 1'b0;
      op_start_q  <= 1'b0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      ex_req_q    <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      op_start_q  <= bus.op_start;
      done_flag_q <= done_flag_d;
      // Using the next-state flag makes interrupt rise in the cycle after DONE.
      interrupt_q <= done_flag_d & bus.int_mask;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;

      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            pc_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          ex_op_q <= dec_opc;
          dst_q   <= dec_dst;
          src1_q  <= dec_src1;
          src2_q  <= dec_src2;
          if (dec_opc == OPC_END) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_INTERRUPT;
            wr_data_q <= status_word(err_q);
            state_q   <= ST_DONE;
          end else if (dec_bad) begin
            err_q     <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_INTERRUPT;
            wr_data_q <= status_word(1'b1);
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_RDA;
          end
        end

        ST_RDA: begin
          ex_a_q  <= bus.rd_data;
          state_q <= ST_RDB;
        end

        ST_RDB: begin
          ex_b_q   <= bus.rd_data;
          ex_req_q <= 1'b1;
          state_q  <= ST_EXEC;
        end

        ST_EXEC: begin
          if (bus.ex_ack) begin
            ex_req_q  <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_R0 + {12'b0, dst_q};
            wr_data_q <= bus.ex_result;
            state_q   <= ST_WB;
          end
        end

        ST_WB: begin
          if (pc_q == PC_LAST) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_INTERRUPT;
            wr_data_q <= status_word(err_q);
            state_q   <= ST_DONE;
          end else begin
            pc_q    <= pc_q + 4'd1;
            state_q <= ST_FETCH;
          end
        end

        ST_DONE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ADDR_OP_START;
          wr_data_q <= '0;
          state_q   <= ST_CLR;
        end

        ST_CLR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_addr   = rd_mux_addr;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.ex_req    = ex_req_q;
  assign bus.ex_op     = ex_op_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.busy      = busy_q;
  assign bus.interrupt = interrupt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: behavioural register bank, latency-programmable
// execution stub, write log checked against an expected queue.
module tb_op_sequencer;
  import op_sequencer_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  op_sequencer_if bus();

  op_sequencer #(.N_INSTR(10), .N_OPND(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // bank model and execution stub
  logic [63:0] bank [0:22] = '{default: 64'h0};
  logic        cfg_we   = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [63:0] cfg_data = '0;
  int unsigned ack_lat  = 0;
  int unsigned ack_cnt  = 0;
  logic        stray_ack = 1'b0;

  logic [79:0] wr_log [0:255];
  int wr_cnt      = 0;
  int busy_cycles = 0;
  int req_cycles  = 0;
  int idle_bad    = 0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [79:0] exp_q[$];
  int rd_ptr = 0;

  function automatic logic [63:0] alu(input logic [3:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [3:0] dst,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, 48'h0, dst, s1, s2};
  endfunction

  function automatic logic [79:0] wr(input logic [15:0] a, input logic [63:0] d);
    return {a, d};
  endfunction

  assign bus.op_start  = bank[20][0];
  assign bus.int_mask  = bank[21][0];
  assign bus.rd_data   = (bus.rd_addr < 16'd23) ? bank[bus.rd_addr[4:0]] : 64'h0;
  assign bus.ex_ack    = (bus.ex_req && (ack_cnt >= ack_lat)) || stray_ack;
  assign bus.ex_result = alu(bus.ex_op, bus.ex_a, bus.ex_b);

  always @(posedge clk) ack_cnt <= bus.ex_req ? ack_cnt + 1 : 0;

  always @(negedge clk) begin
    if (cfg_we) bank[cfg_addr] = cfg_data;
    if (bus.wr_en) begin
      wr_log[wr_cnt[7:0]] = {bus.wr_addr, bus.wr_data};
      wr_cnt++;
      if (bus.wr_addr < 16'd23) bank[bus.wr_addr[4:0]] = bus.wr_data;
    end else if (bus.wr_addr != 16'h0 || bus.wr_data != 64'h0) begin
      idle_bad++;
    end
    if (bus.busy)   busy_cycles++;
    if (bus.ex_req) req_cycles++;
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [63:0] d);
    #1;
    cfg_addr = a;
    cfg_data = d;
    cfg_we   = 1'b1;
    @(negedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wait_state(input state_e s, input int max, input string tag);
    int n = 0;
    while (bus.dbg_state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {77'b0, bus.dbg_state}, {77'b0, s});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 2000);
    check(tag, {79'b0, bus.busy}, 80'h0);
  endtask

  task automatic check_writes(input string tag);
    logic [79:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < wr_cnt) begin
        check(tag, wr_log[rd_ptr[7:0]], e);
        rd_ptr++;
      end else begin
        n_tests++;
        n_fail++;
        $error("FAIL %s_missing: observed none required 0x%0h", tag, e);
      end
    end
    check({tag, "_count"}, 80'(wr_cnt), 80'(rd_ptr));
    rd_ptr = wr_cnt;
  endtask

  // directed sequence
  initial begin
    int b0, r0, w0;

    repeat (3) @(negedge clk);
    check("rst_busy",  {79'b0, bus.busy},      80'h0);
    check("rst_req",   {79'b0, bus.ex_req},    80'h0);
    check("rst_wren",  {79'b0, bus.wr_en},     80'h0);
    check("rst_irq",   {79'b0, bus.interrupt}, 80'h0);
    check("rst_rdadr", {64'b0, bus.rd_addr},   80'h0);
    check("rst_state", {77'b0, bus.dbg_state}, {77'b0, ST_IDLE});
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single add, 3-cycle ack wait
    set_reg(0, 64'd5);
    set_reg(1, 64'd7);
    set_reg(10, mk(4'h1, 4'd2, 4'd0, 4'd1));
    set_reg(11, 64'h0);
    set_reg(21, 64'h1);
    ack_lat = 3;
    set_reg(20, 64'h1);
    wait_state(ST_DONE, 40, "t1_reach_done");
    check("t1_irq_in_done", {79'b0, bus.interrupt}, 80'h0);
    @(negedge clk);
    check("t1_irq_after_done", {79'b0, bus.interrupt}, 80'h1);
    wait_idle("t1_idle");
    exp_q.push_back(wr(16'h0002, 64'd12));
    exp_q.push_back(wr(16'h0016, 64'h1));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t1_wr");
    check("t1_irq_hold", {79'b0, bus.interrupt}, 80'h1);

    // 2: ten chained instructions, zero-wait ack
    set_reg(0, 64'd1);
    set_reg(1, 64'd2);
    set_reg(10, mk(4'h1, 4'd2, 4'd0, 4'd1));
    set_reg(11, mk(4'h1, 4'd3, 4'd2, 4'd1));
    set_reg(12, mk(4'h1, 4'd4, 4'd3, 4'd2));
    set_reg(13, mk(4'h1, 4'd5, 4'd4, 4'd3));
    set_reg(14, mk(4'h1, 4'd6, 4'd5, 4'd4));
    set_reg(15, mk(4'h1, 4'd7, 4'd6, 4'd5));
    set_reg(16, mk(4'h1, 4'd8, 4'd7, 4'd6));
    set_reg(17, mk(4'h1, 4'd9, 4'd8, 4'd7));
    set_reg(18, mk(4'h2, 4'd0, 4'd9, 4'd8));
    set_reg(19, mk(4'h3, 4'd0, 4'd0, 4'd1));
    ack_lat = 0;
    b0 = busy_cycles;
    set_reg(20, 64'h1);
    wait_idle("t2_idle");
    check("t2_busy_cycles", 80'(busy_cycles - b0), 80'd52);
    exp_q.push_back(wr(16'h0002, 64'd3));
    exp_q.push_back(wr(16'h0003, 64'd5));
    exp_q.push_back(wr(16'h0004, 64'd8));
    exp_q.push_back(wr(16'h0005, 64'd13));
    exp_q.push_back(wr(16'h0006, 64'd21));
    exp_q.push_back(wr(16'h0007, 64'd34));
    exp_q.push_back(wr(16'h0008, 64'd55));
    exp_q.push_back(wr(16'h0009, 64'd89));
    exp_q.push_back(wr(16'h0000, 64'd34));
    exp_q.push_back(wr(16'h0000, 64'd32));
    exp_q.push_back(wr(16'h0016, 64'h1));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t2_wr");

    // 3: out-of-range source index
    set_reg(10, mk(4'h1, 4'd2, 4'hC, 4'd1));
    r0 = req_cycles;
    set_reg(20, 64'h1);
    wait_idle("t3_idle");
    check("t3_no_req", 80'(req_cycles - r0), 80'd0);
    exp_q.push_back(wr(16'h0016, 64'h3));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t3_wr");
    check("t3_irq", {79'b0, bus.interrupt}, 80'h1);

    // 4: masked completion, later unmask
    set_reg(21, 64'h0);
    set_reg(10, 64'h0);
    set_reg(20, 64'h1);
    wait_idle("t4_idle");
    exp_q.push_back(wr(16'h0016, 64'h1));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t4_wr");
    check("t4_irq_masked", {79'b0, bus.interrupt}, 80'h0);
    set_reg(21, 64'h1);
    check("t4_irq_same_cycle", {79'b0, bus.interrupt}, 80'h0);
    @(negedge clk);
    check("t4_irq_unmasked", {79'b0, bus.interrupt}, 80'h1);

    // 5: op_start toggled during EXEC, stray ack outside EXEC
    set_reg(0, 64'd5);
    set_reg(3, 64'd10);
    set_reg(10, mk(4'h1, 4'd3, 4'd3, 4'd3));
    set_reg(11, mk(4'h2, 4'd4, 4'd3, 4'd0));
    set_reg(12, 64'h0);
    ack_lat = 4;
    set_reg(20, 64'h1);
    wait_state(ST_EXEC, 20, "t5_reach_exec");
    set_reg(20, 64'h0);
    set_reg(20, 64'h1);
    check("t5_still_exec", {77'b0, bus.dbg_state}, {77'b0, ST_EXEC});
    wait_state(ST_RDA, 20, "t5_reach_rda");
    #1 stray_ack = 1'b1;
    @(negedge clk);
    #1 stray_ack = 1'b0;
    wait_idle("t5_idle");
    exp_q.push_back(wr(16'h0003, 64'd20));
    exp_q.push_back(wr(16'h0004, 64'd15));
    exp_q.push_back(wr(16'h0016, 64'h1));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t5_wr");
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    check("t5_no_rerun_busy", {79'b0, bus.busy}, 80'h0);
    check("t5_no_rerun_wr", 80'(wr_cnt), 80'(w0));

    // 6: reset asserted during EXEC
    set_reg(0, 64'd5);
    set_reg(1, 64'd7);
    set_reg(10, mk(4'h1, 4'd5, 4'd0, 4'd1));
    set_reg(11, 64'h0);
    ack_lat = 6;
    set_reg(20, 64'h1);
    wait_state(ST_EXEC, 20, "t6_reach_exec");
    w0 = wr_cnt;
    reset_n = 1'b0;
    #1;
    check("t6_rst_req",   {79'b0, bus.ex_req}, 80'h0);
    check("t6_rst_busy",  {79'b0, bus.busy},   80'h0);
    check("t6_rst_wren",  {79'b0, bus.wr_en},  80'h0);
    check("t6_rst_state", {77'b0, bus.dbg_state}, {77'b0, ST_IDLE});
    set_reg(20, 64'h0);
    repeat (3) @(negedge clk);
    check("t6_no_writes", 80'(wr_cnt), 80'(w0));
    reset_n = 1'b1;
    @(negedge clk);
    ack_lat = 1;
    set_reg(20, 64'h1);
    wait_idle("t6_idle");
    exp_q.push_back(wr(16'h0005, 64'd12));
    exp_q.push_back(wr(16'h0016, 64'h1));
    exp_q.push_back(wr(16'h0014, 64'h0));
    check_writes("t6_wr");

    check("idle_bus_zero", 80'(idle_bad), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
